// File: rtl/ar_request_fifo_v2_if.sv
// AR channel bundle: valid/ready handshake plus id/addr/len/size/burst/qos payload.
// valid/ready: a beat transfers on a clock edge where valid and ready are both 1; payload is held while valid & ~ready.
interface ar_if #(
    parameter int ID_WIDTH    = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH   = 8,
    parameter int SIZE_WIDTH  = 3,
    parameter int BURST_WIDTH = 2,
    parameter int QOS_WIDTH   = 4
);
    logic                   valid;
    logic                   ready;
    logic [ID_WIDTH-1:0]    id;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [LEN_WIDTH-1:0]   len;
    logic [SIZE_WIDTH-1:0]  size;
    logic [BURST_WIDTH-1:0] burst;
    logic [QOS_WIDTH-1:0]   qos;

    modport receiver (input valid, id, addr, len, size, burst, qos, output ready);
    modport sender   (output valid, id, addr, len, size, burst, qos, input ready);
endinterface

// File: rtl/ar_request_fifo_v2.sv
// In-order AR request FIFO, any DEPTH >= 2, with occupancy/almost_full/high-water-mark outputs.
// Define AR_FIFO_BYPASS_EN to let an empty queue forward ar_in straight to ar_out in the same cycle.
module ar_request_fifo_v2 #(
    parameter int ID_WIDTH    = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH   = 8,
    parameter int SIZE_WIDTH  = 3,
    parameter int BURST_WIDTH = 2,
    parameter int QOS_WIDTH   = 4,
    parameter int DEPTH       = 8,
    parameter int AF_THRESH   = 6,
    localparam int PTR_W      = (DEPTH > 2) ? $clog2(DEPTH) : 1,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    ar_if.receiver           ar_in,
    ar_if.sender             ar_out,
    input  logic             flush,
    output logic [CNT_W-1:0] level,
    output logic             almost_full,
    output logic [CNT_W-1:0] hwm
);
    localparam int PW = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + SIZE_WIDTH + BURST_WIDTH + QOS_WIDTH;

    logic [PW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_next, hwm_next;
    logic [PW-1:0]    in_payload, out_payload;
    logic             count_zero, count_full, in_ready, out_valid;
    logic             bypass, push, pop, wr_en, rd_en;

    assign in_payload = {ar_in.id, ar_in.addr, ar_in.len, ar_in.size, ar_in.burst, ar_in.qos};
    assign count_zero = (count == '0);
    assign count_full = (count == CNT_W'(DEPTH));
    assign in_ready   = ~count_full & ~flush;

`ifdef AR_FIFO_BYPASS_EN
    // Empty queue: ar_out mirrors ar_in combinationally.
    assign bypass      = count_zero & ~flush;
    assign out_valid   = (bypass & ar_in.valid) | (~count_zero & ~flush);
    assign out_payload = bypass ? in_payload : mem[rd_ptr];
`else
    assign bypass      = 1'b0;
    assign out_valid   = ~count_zero & ~flush;
    assign out_payload = mem[rd_ptr];
`endif

    assign ar_in.ready  = in_ready;
    assign ar_out.valid = out_valid;
    assign {ar_out.id, ar_out.addr, ar_out.len, ar_out.size, ar_out.burst, ar_out.qos} = out_payload;

    assign push  = ar_in.valid & in_ready;
    assign pop   = out_valid & ar_out.ready;
    // A bypassed transfer never touches storage.
    assign wr_en = push & ~(bypass & pop);
    assign rd_en = pop & ~bypass;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   count_next = count + CNT_W'(1);
                2'b01:   count_next = count - CNT_W'(1);
                default: count_next = count;
            endcase
        end
        hwm_next = (count_next > hwm) ? count_next : hwm;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hwm    <= '0;
        end else begin
            count <= count_next;
            hwm   <= hwm_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_en) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
                if (rd_en) rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= in_payload;
    end

    assign level       = count;
    assign almost_full = (count >= CNT_W'(AF_THRESH));
endmodule

// File: tb/tb_ar_request_fifo_v2.sv
// Directed bench for ar_request_fifo_v2: fill, concurrent push/pop, wrap/order, flush, reset, bypass.
module tb_ar_request_fifo_v2;
    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [3:0] level;
    logic       almost_full;
    logic [3:0] hwm;
    int         n_cmp;
    int         n_fail;
    logic [7:0] exp_q[$];

    ar_if in_bus ();
    ar_if out_bus ();

    ar_request_fifo_v2 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ar_in       (in_bus),
        .ar_out      (out_bus),
        .flush       (flush),
        .level       (level),
        .almost_full (almost_full),
        .hwm         (hwm)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    // drivers: inputs change on the falling edge, checks follow at +1
    task automatic drive(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
        @(negedge clk);
        in_bus.valid = iv;
        in_bus.id    = id;
        in_bus.addr  = 32'hA000_0000 | {24'h0, id};
        in_bus.len   = id;
        in_bus.size  = id[2:0];
        in_bus.burst = 2'b01;
        in_bus.qos   = id[3:0];
        out_bus.ready = ordy;
        flush = fl;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_bus.valid = 1'b0;
        out_bus.ready = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        in_bus.valid = 1'b0;
        out_bus.ready = 1'b0;
        #1;
        n_cmp++; if (out_bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_bus.valid); end
        n_cmp++; if (in_bus.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", in_bus.ready); end
        n_cmp++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", level); end
        n_cmp++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af got=%b exp=0", almost_full); end
        n_cmp++; if (hwm !== 4'd0) begin n_fail++; $display("FAIL reset_hwm got=%0d exp=0", hwm); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            #1;
            n_cmp++; if (in_bus.ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, in_bus.ready); end
            n_cmp++; if (level !== 4'(i)) begin n_fail++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, level, i); end
            n_cmp++; if (almost_full !== (i >= 6)) begin n_fail++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, almost_full, (i >= 6)); end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        n_cmp++; if (level !== 4'd8) begin n_fail++; $display("FAIL full_level got=%0d exp=8", level); end
        n_cmp++; if (in_bus.ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%b exp=0", in_bus.ready); end
        n_cmp++; if (almost_full !== 1'b1) begin n_fail++; $display("FAIL full_af got=%b exp=1", almost_full); end
        n_cmp++; if (hwm !== 4'd8) begin n_fail++; $display("FAIL full_hwm got=%0d exp=8", hwm); end
        // push attempt while full with a simultaneous pop must be refused
        drive(1'b1, 8'hEE, 1'b1, 1'b0);
        #1;
        n_cmp++; if (in_bus.ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_ready got=%b exp=0", in_bus.ready); end
        n_cmp++; if (out_bus.id !== 8'h00) begin n_fail++; $display("FAIL drain_id[0] got=%h exp=00", out_bus.id); end
        for (int i = 1; i < 8; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            #1;
            n_cmp++; if (out_bus.valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d] got=%b exp=1", i, out_bus.valid); end
            n_cmp++; if (out_bus.id !== 8'(i)) begin n_fail++; $display("FAIL drain_id[%0d] got=%h exp=%h", i, out_bus.id, 8'(i)); end
            n_cmp++; if (out_bus.addr !== (32'hA000_0000 | i)) begin n_fail++; $display("FAIL drain_addr[%0d] got=%h exp=%h", i, out_bus.addr, 32'hA000_0000 | i); end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        n_cmp++; if (level !== 4'd0) begin n_fail++; $display("FAIL drain_level got=%0d exp=0", level); end
        n_cmp++; if (out_bus.valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid_end got=%b exp=0", out_bus.valid); end
        n_cmp++; if (hwm !== 4'd8) begin n_fail++; $display("FAIL drain_hwm got=%0d exp=8", hwm); end
    endtask

    task automatic test_concurrent();
        logic [7:0] exp_ids [4];
        exp_ids = '{8'h21, 8'h22, 8'h23, 8'h11};
        drive(1'b1, 8'h21, 1'b0, 1'b0);
        drive(1'b1, 8'h22, 1'b0, 1'b0);
        drive(1'b1, 8'h23, 1'b0, 1'b0);
        drive(1'b1, 8'h11, 1'b1, 1'b0);
        #1;
        n_cmp++; if (level !== 4'd3) begin n_fail++; $display("FAIL conc_level_pre got=%0d exp=3", level); end
        n_cmp++; if (out_bus.id !== exp_ids[0]) begin n_fail++; $display("FAIL conc_id[0] got=%h exp=%h", out_bus.id, exp_ids[0]); end
        for (int i = 1; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            #1;
            if (i == 1) begin
                n_cmp++; if (level !== 4'd3) begin n_fail++; $display("FAIL conc_level_post got=%0d exp=3", level); end
            end
            n_cmp++; if (out_bus.id !== exp_ids[i]) begin n_fail++; $display("FAIL conc_id[%0d] got=%h exp=%h", i, out_bus.id, exp_ids[i]); end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        n_cmp++; if (level !== 4'd0) begin n_fail++; $display("FAIL conc_level_end got=%0d exp=0", level); end
    endtask

    task automatic test_wrap_order();
        int sent, got, cyc;
        logic [7:0] exp_id;
        sent = 0; got = 0; cyc = 0;
        exp_q.delete();
        while ((got < 20) && (cyc < 400)) begin
            drive(sent < 20, 8'(sent), 1'($urandom_range(0, 1)), 1'b0);
            #1;
            if (out_bus.valid & out_bus.ready) begin
                exp_id = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                n_cmp++; if (out_bus.id !== exp_id) begin n_fail++; $display("FAIL wrap_id[%0d] got=%h exp=%h", got, out_bus.id, exp_id); end
                got++;
            end
            if (in_bus.valid & in_bus.ready) begin
                exp_q.push_back(8'(sent));
                sent++;
            end
            cyc++;
        end
        n_cmp++; if (got != 20) begin n_fail++; $display("FAIL wrap_count got=%0d exp=20", got); end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        n_cmp++; if (level !== 4'd0) begin n_fail++; $display("FAIL wrap_level got=%0d exp=0", level); end
    endtask

    task automatic test_flush();
        apply_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        drive(1'b1, 8'h99, 1'b1, 1'b1);
        #1;
        n_cmp++; if (level !== 4'd5) begin n_fail++; $display("FAIL flush_level_pre got=%0d exp=5", level); end
        n_cmp++; if (out_bus.valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", out_bus.valid); end
        n_cmp++; if (in_bus.ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got=%b exp=0", in_bus.ready); end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        n_cmp++; if (level !== 4'd0) begin n_fail++; $display("FAIL flush_level got=%0d exp=0", level); end
        n_cmp++; if (out_bus.valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid_after got=%b exp=0", out_bus.valid); end
        n_cmp++; if (hwm !== 4'd5) begin n_fail++; $display("FAIL flush_hwm got=%0d exp=5", hwm); end
        n_cmp++; if (in_bus.ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready_after got=%b exp=1", in_bus.ready); end
        drive(1'b1, 8'h42, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        n_cmp++; if (out_bus.id !== 8'h42) begin n_fail++; $display("FAIL flush_repush_id got=%h exp=42", out_bus.id); end
        n_cmp++; if (level !== 4'd1) begin n_fail++; $display("FAIL flush_repush_level got=%0d exp=1", level); end
    endtask

    task automatic test_reset_mid_op();
        apply_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        n_cmp++; if (level !== 4'd4) begin n_fail++; $display("FAIL rst_mid_level_pre got=%0d exp=4", level); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_bus.valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got=%b exp=0", out_bus.valid); end
        n_cmp++; if (level !== 4'd0) begin n_fail++; $display("FAIL rst_mid_level got=%0d exp=0", level); end
        n_cmp++; if (hwm !== 4'd0) begin n_fail++; $display("FAIL rst_mid_hwm got=%0d exp=0", hwm); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        n_cmp++; if (out_bus.valid !== 1'b1) begin n_fail++; $display("FAIL rst_push_valid got=%b exp=1", out_bus.valid); end
        n_cmp++; if (out_bus.id !== 8'h77) begin n_fail++; $display("FAIL rst_push_id got=%h exp=77", out_bus.id); end
        n_cmp++; if (level !== 4'd1) begin n_fail++; $display("FAIL rst_push_level got=%0d exp=1", level); end
    endtask

`ifdef AR_FIFO_BYPASS_EN
    task automatic test_bypass();
        apply_reset();
        drive(1'b1, 8'h5A, 1'b1, 1'b0);
        #1;
        n_cmp++; if (out_bus.valid !== 1'b1) begin n_fail++; $display("FAIL bypass_valid got=%b exp=1", out_bus.valid); end
        n_cmp++; if (out_bus.id !== 8'h5A) begin n_fail++; $display("FAIL bypass_id got=%h exp=5a", out_bus.id); end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        n_cmp++; if (level !== 4'd0) begin n_fail++; $display("FAIL bypass_level got=%0d exp=0", level); end
        n_cmp++; if (hwm !== 4'd0) begin n_fail++; $display("FAIL bypass_hwm got=%0d exp=0", hwm); end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_fill();
        test_concurrent();
        test_wrap_order();
        test_flush();
        test_reset_mid_op();
`ifdef AR_FIFO_BYPASS_EN
        test_bypass();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
